// File: rtl/spw_tx_pkg.sv
// Shared definitions for the SpaceWire TX staging path.
//   FCT_CREDIT_STEP : credits granted by one received FCT
//   CREDIT_MAX      : largest credit value the link may hold
//   NCHAR_EOP/EEP   : N-char control codes (bit 8 set = control character)
//   tcode_state_t   : time-code handshake states
package spw_tx_pkg;

   localparam int FCT_CREDIT_STEP = 8;
   localparam int CREDIT_MAX      = 56;

   localparam logic [8:0] NCHAR_EOP = 9'h100;
   localparam logic [8:0] NCHAR_EEP = 9'h101;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } tcode_state_t;

endpackage

// File: rtl/tx_stage_fifo.sv
// Small register-array FIFO holding N-chars waiting for the encoder.
// Ports:
//   clk, resetn     : clock, async active-low reset
//   clear           : synchronous clear (empties FIFO and zeroes storage)
//   push, wr_data   : write strobe and data (ignored when full)
//   pop             : read strobe (ignored when empty)
//   rd_data         : head entry, read straight from the register array
//   full, empty     : derived from the registered occupancy count
module tx_stage_fifo #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   // Storage is zeroed on clear so the head output reads 0 while disabled.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;   // DEPTH is a power of 2: natural wrap
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tx_data_stage.sv
// TX staging block between the host write interface and the SpaceWire TX
// encoder: DEPTH-entry N-char FIFO, optional FCT credit gate, and a single
// pending time-code slot with ready/ack handshake.
// Build option: define TX_CREDIT_EN to enable the FCT credit counter; without
// it process_data = FIFO not empty, fct_rcvd is ignored, credit_err is 0.
// Ports:
//   pclk_tx, resetn    : clock, async active-low reset
//   enable_tx          : 0 clears FIFO, credits, time-code state on next edge
//   data_tx_i, txwrite_tx, ready_tx          : host push side
//   tx_data_in, process_data, get_data       : encoder pop side
//   fct_rcvd, credit_err, credit             : credit input, overflow pulse, debug view
//   timecode_tx_i, tickin_tx                 : time-code request
//   tx_tcode_in, tcode_rdy_trnsp, tcode_ack  : time-code handshake to encoder
//   tick_drop, tcode_state                   : overwrite pulse, FSM debug view
// Handshakes: a push happens on an edge where txwrite_tx & ready_tx; a pop
// happens where get_data & process_data; a time-code is taken where
// tcode_rdy_trnsp & tcode_ack. Strobes without their qualifier are ignored.
module tx_data_stage
   import spw_tx_pkg::*;
#(
   parameter int DATA_W   = 9,
   parameter int DEPTH    = 4,
   parameter int CREDIT_W = 6
) (
   input  logic                pclk_tx,
   input  logic                resetn,
   input  logic                enable_tx,
   input  logic [DATA_W-1:0]   data_tx_i,
   input  logic                txwrite_tx,
   output logic                ready_tx,
   input  logic                fct_rcvd,
   input  logic                get_data,
   output logic [DATA_W-1:0]   tx_data_in,
   output logic                process_data,
   input  logic [7:0]          timecode_tx_i,
   input  logic                tickin_tx,
   input  logic                tcode_ack,
   output logic [7:0]          tx_tcode_in,
   output logic                tcode_rdy_trnsp,
   output logic                credit_err,
   output logic                tick_drop,
   output logic [CREDIT_W-1:0] credit,
   output tcode_state_t        tcode_state
);

   logic en_q;
   logic full;
   logic empty;
   logic push;
   logic pop;

   // en_q keeps ready_tx low in reset and in the cycle after a clear.
   always_ff @(posedge pclk_tx or negedge resetn) begin
      if (!resetn) en_q <= 1'b0;
      else         en_q <= enable_tx;
   end

   assign ready_tx = en_q & ~full;
   assign push     = txwrite_tx & ready_tx;
   assign pop      = get_data & process_data;

   tx_stage_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (pclk_tx),
      .resetn  (resetn),
      .clear   (~enable_tx),
      .push    (push),
      .wr_data (data_tx_i),
      .pop     (pop),
      .rd_data (tx_data_in),
      .full    (full),
      .empty   (empty)
   );

`ifdef TX_CREDIT_EN
   logic [CREDIT_W-1:0] credit_q;
   logic [CREDIT_W-1:0] credit_after_pop;
   logic [CREDIT_W:0]   credit_sum;
   logic                credit_err_q;

   // Overflow is judged after the same-cycle pop has been taken off.
   assign credit_after_pop = credit_q - CREDIT_W'(pop);
   assign credit_sum       = {1'b0, credit_after_pop} + (CREDIT_W+1)'(FCT_CREDIT_STEP);

   always_ff @(posedge pclk_tx or negedge resetn) begin
      if (!resetn) begin
         credit_q     <= '0;
         credit_err_q <= 1'b0;
      end else if (!enable_tx) begin
         credit_q     <= '0;
         credit_err_q <= 1'b0;
      end else begin
         credit_err_q <= 1'b0;
         if (fct_rcvd && (credit_sum > (CREDIT_W+1)'(CREDIT_MAX))) begin
            credit_q     <= credit_after_pop;
            credit_err_q <= 1'b1;
         end else if (fct_rcvd) begin
            credit_q <= credit_sum[CREDIT_W-1:0];
         end else begin
            credit_q <= credit_after_pop;
         end
      end
   end

   assign process_data = ~empty & (credit_q != '0);
   assign credit_err   = credit_err_q;
   assign credit       = credit_q;
`else
   logic unused_fct;
   assign unused_fct   = fct_rcvd;
   assign process_data = ~empty;
   assign credit_err   = 1'b0;
   assign credit       = '0;
`endif

   // Time-code slot: one pending value, a newer request always overwrites.
   tcode_state_t state_q;
   tcode_state_t state_d;
   logic [7:0]   tcode_q;
   logic         load;
   logic         drop_d;
   logic         drop_q;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      drop_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (tickin_tx) begin
               load    = 1'b1;
               state_d = PEND;
            end
         end
         PEND: begin
            if (tickin_tx) begin
               load   = 1'b1;
               // Acked in the same cycle: the old value was delivered, not lost.
               drop_d = ~tcode_ack;
            end else if (tcode_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk_tx or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         tcode_q <= '0;
         drop_q  <= 1'b0;
      end else if (!enable_tx) begin
         state_q <= IDLE;
         tcode_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         if (load) tcode_q <= timecode_tx_i;
      end
   end

   assign tx_tcode_in     = tcode_q;
   assign tcode_rdy_trnsp = (state_q == PEND);
   assign tick_drop       = drop_q;
   assign tcode_state     = state_q;

endmodule
